// File: rtl/time_set_pkg.sv
// Shared constants for the watch time-set editor: mode codes, cursor positions,
// FSM encoding and per-field limits.
package time_set_pkg;

   localparam logic [3:0] MODE_NORMAL   = 4'b0000;
   localparam logic [3:0] MODE_TIME_SET = 4'b0001;

   localparam logic [2:0] CUR_SEC_U  = 3'd0;
   localparam logic [2:0] CUR_SEC_T  = 3'd1;
   localparam logic [2:0] CUR_MIN_U  = 3'd2;
   localparam logic [2:0] CUR_MIN_T  = 3'd3;
   localparam logic [2:0] CUR_HOUR_U = 3'd4;
   localparam logic [2:0] CUR_HOUR_T = 3'd5;
   localparam logic [2:0] CUR_AMPM   = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [6:0] SEC_MAX = 7'd59;
   localparam logic [6:0] H12_MAX = 7'd11;
   localparam logic [6:0] H24_MAX = 7'd23;

endpackage

// File: rtl/time_set_editor_if.sv
// Button/snapshot inputs and edited-time outputs of the time-set editor.
interface time_set_editor_if;

   logic [3:0] num_sync;
   logic [3:0] mode;
   logic [6:0] cur_hour;
   logic [6:0] cur_min;
   logic [6:0] cur_sec;
   logic       cur_meridiem;
   logic [2:0] cursor;
   logic [6:0] hour;
   logic [6:0] min;
   logic [6:0] sec;
   logic       meridiem;
   logic       load_req;
   logic       blink;

   modport master (
      output num_sync, mode, cur_hour, cur_min, cur_sec, cur_meridiem,
      input  cursor, hour, min, sec, meridiem, load_req, blink
   );

   modport slave (
      input  num_sync, mode, cur_hour, cur_min, cur_sec, cur_meridiem,
      output cursor, hour, min, sec, meridiem, load_req, blink
   );

endinterface

// File: rtl/field_digit_step.sv
// Steps one decimal digit of a two-digit time field up or down, wrapping within the
// field's legal range and clamping to the limit when a tens change makes it illegal.
module field_digit_step (
   input  logic [6:0] value,
   input  logic       tens_sel,
   input  logic       up,
   input  logic [6:0] limit,
   output logic [6:0] result
);

   logic [3:0] units;
   logic [3:0] tens;
   logic [3:0] lim_units;
   logic [3:0] lim_tens;
   logic [3:0] units_top;
   logic [3:0] units_n;
   logic [3:0] tens_n;

   always_comb begin
      units     = 4'(value % 7'd10);
      tens      = 4'(value / 7'd10);
      lim_units = 4'(limit % 7'd10);
      lim_tens  = 4'(limit / 7'd10);
      // The units digit only runs short when the tens digit is at its top value (e.g. 2x of 23).
      units_top = (tens == lim_tens) ? lim_units : 4'd9;
      units_n   = units;
      tens_n    = tens;
      result    = limit;
      if (value <= limit) begin
         if (!tens_sel) begin
            if (up) units_n = (units >= units_top) ? 4'd0 : units + 4'd1;
            else    units_n = (units == 4'd0) ? units_top : units - 4'd1;
            result = 7'(tens) * 7'd10 + 7'(units_n);
         end else begin
            if (up) tens_n = (tens >= lim_tens) ? 4'd0 : tens + 4'd1;
            else    tens_n = (tens == 4'd0) ? lim_tens : tens - 4'd1;
            if (tens_n == lim_tens && units > lim_units) result = limit;
            else                                         result = 7'(tens_n) * 7'd10 + 7'(units);
         end
      end
   end

endmodule

// File: rtl/time_set_editor.sv
// Cursor-based time editor: snapshots running time on entering the set mode, edits
// digits with up/down buttons, blinks the selected digit and issues a commit pulse on exit.
module time_set_editor
   import time_set_pkg::*;
#(
   parameter logic [3:0] ACTIVE_MODE = MODE_TIME_SET,
   parameter bit         H24         = 1'b0,
   parameter int         BLINK_DIV   = 25000000
) (
   input logic              CLK,
   input logic              RESET,
   time_set_editor_if.slave bus
);

   localparam logic [2:0] CUR_MAX  = H24 ? CUR_HOUR_T : CUR_AMPM;
   localparam logic [6:0] HOUR_MAX = H24 ? H24_MAX : H12_MAX;
   localparam int         CNT_W    = $clog2(BLINK_DIV);

   state_t           state_reg;
   state_t           state_next;
   logic [2:0]       cursor_reg;
   logic [6:0]       hour_reg;
   logic [6:0]       min_reg;
   logic [6:0]       sec_reg;
   logic             meridiem_reg;
   logic             blink_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic             in_edit;
   logic             entering;
   logic             do_step;
   logic             do_next;
   logic             do_prev;
   logic [6:0]       step_val;
   logic [6:0]       step_lim;
   logic [6:0]       step_res;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (bus.mode == ACTIVE_MODE) state_next = ST_EDIT;
         ST_EDIT:   if (bus.mode != ACTIVE_MODE) state_next = ST_COMMIT;
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_edit  = (state_reg == ST_EDIT);
      entering = (state_reg == ST_IDLE) && (state_next == ST_EDIT);
      do_step  = in_edit && (bus.num_sync[0] ^ bus.num_sync[1]);
      do_next  = in_edit && bus.num_sync[2] && !bus.num_sync[3];
      do_prev  = in_edit && bus.num_sync[3] && !bus.num_sync[2];
      step_val = sec_reg;
      step_lim = SEC_MAX;
      case (cursor_reg)
         CUR_MIN_U, CUR_MIN_T: begin
            step_val = min_reg;
         end
         CUR_HOUR_U, CUR_HOUR_T: begin
            step_val = hour_reg;
            step_lim = HOUR_MAX;
         end
         default: ;
      endcase
   end

   // Shared stepper; the value/cursor update below always uses the pre-move cursor.
   field_digit_step u_step (
      .value    (step_val),
      .tens_sel (cursor_reg[0]),
      .up       (bus.num_sync[0]),
      .limit    (step_lim),
      .result   (step_res)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cursor_reg   <= 3'd0;
         hour_reg     <= 7'd0;
         min_reg      <= 7'd0;
         sec_reg      <= 7'd0;
         meridiem_reg <= 1'b0;
      end else if (entering) begin
         cursor_reg   <= 3'd0;
         hour_reg     <= bus.cur_hour;
         min_reg      <= bus.cur_min;
         sec_reg      <= bus.cur_sec;
         meridiem_reg <= H24 ? 1'b0 : bus.cur_meridiem;
      end else if (in_edit) begin
         if (do_step) begin
            case (cursor_reg)
               CUR_SEC_U, CUR_SEC_T:   sec_reg  <= step_res;
               CUR_MIN_U, CUR_MIN_T:   min_reg  <= step_res;
               CUR_HOUR_U, CUR_HOUR_T: hour_reg <= step_res;
               default:                meridiem_reg <= H24 ? 1'b0 : ~meridiem_reg;
            endcase
         end
         if (do_next)      cursor_reg <= (cursor_reg == CUR_MAX) ? 3'd0 : cursor_reg + 3'd1;
         else if (do_prev) cursor_reg <= (cursor_reg == 3'd0) ? CUR_MAX : cursor_reg - 3'd1;
      end else if (state_reg == ST_COMMIT) begin
         cursor_reg <= 3'd0;
      end
   end

   // Blink phase restarts (digit shown) on entry and on every button press.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         blink_reg <= 1'b1;
         cnt_reg   <= '0;
      end else if (state_next != ST_EDIT || !in_edit || (|bus.num_sync)) begin
         blink_reg <= 1'b1;
         cnt_reg   <= '0;
      end else if (cnt_reg == CNT_W'(BLINK_DIV - 1)) begin
         blink_reg <= ~blink_reg;
         cnt_reg   <= '0;
      end else begin
         cnt_reg   <= cnt_reg + CNT_W'(1);
      end
   end

   assign bus.cursor   = cursor_reg;
   assign bus.hour     = hour_reg;
   assign bus.min      = min_reg;
   assign bus.sec      = sec_reg;
   assign bus.meridiem = meridiem_reg;
   assign bus.load_req = (state_reg == ST_COMMIT);
   assign bus.blink    = blink_reg;

endmodule
